// File: rtl/alu_multicycle.sv
// Execute-stage ALU with valid/ready handshakes on both sides.
// Logic, arithmetic and compare ops take one cycle; shifts run one bit per cycle.
module alu_multicycle #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [3:0]       ALU_OP_i,
    input  logic [WIDTH-1:0] SRC_A_i,
    input  logic [WIDTH-1:0] SRC_B_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o
);

    localparam int SHAMT_W = $clog2(WIDTH);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_EQ   = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_XOR  = 4'b1000;
    localparam logic [3:0] OP_SUB  = 4'b1010;
    localparam logic [3:0] OP_GE   = 4'b1100;
    localparam logic [3:0] OP_GEU  = 4'b1101;
    localparam logic [3:0] OP_SLT  = 4'b1110;
    localparam logic [3:0] OP_SLTU = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   shreg;
    logic [SHAMT_W-1:0] cnt;
    logic [3:0]         op_q;
    logic               sign_q;

    logic [SHAMT_W-1:0] shamt;
    logic               is_shift;
    logic [WIDTH-1:0]   alu_res;
    logic [WIDTH-1:0]   shift_next;

    assign shamt = SRC_B_i[SHAMT_W-1:0];

    always_comb begin
        is_shift = (ALU_OP_i == OP_SLL) || (ALU_OP_i == OP_SRL) || (ALU_OP_i == OP_SRA);
    end

    // Single-cycle result; shift codes yield A so shamt=0 shifts share this path.
    always_comb begin
        alu_res = '0;
        case (ALU_OP_i)
            OP_AND:  alu_res = SRC_A_i & SRC_B_i;
            OP_OR:   alu_res = SRC_A_i | SRC_B_i;
            OP_ADD:  alu_res = SRC_A_i + SRC_B_i;
            OP_SUB:  alu_res = SRC_A_i - SRC_B_i;
            OP_XOR:  alu_res = SRC_A_i ^ SRC_B_i;
            OP_EQ:   alu_res = {{(WIDTH-1){1'b0}}, SRC_A_i == SRC_B_i};
            OP_GE:   alu_res = {{(WIDTH-1){1'b0}}, $signed(SRC_A_i) >= $signed(SRC_B_i)};
            OP_GEU:  alu_res = {{(WIDTH-1){1'b0}}, SRC_A_i >= SRC_B_i};
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(SRC_A_i) < $signed(SRC_B_i)};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, SRC_A_i < SRC_B_i};
            OP_SLL, OP_SRL, OP_SRA: alu_res = SRC_A_i;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        shift_next = {shreg[WIDTH-2:0], 1'b0};
        if (op_q == OP_SRL) begin
            shift_next = {1'b0, shreg[WIDTH-1:1]};
        end else if (op_q == OP_SRA) begin
            shift_next = {sign_q, shreg[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            ready_o  <= 1'b1;
            valid_o  <= 1'b0;
            result_o <= '0;
            zero_o   <= 1'b1;
            shreg    <= '0;
            cnt      <= '0;
            op_q     <= '0;
            sign_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i && ready_o) begin
                        op_q    <= ALU_OP_i;
                        sign_q  <= SRC_A_i[WIDTH-1];
                        shreg   <= SRC_A_i;
                        cnt     <= shamt;
                        ready_o <= 1'b0;
                        if (is_shift && (shamt != '0)) begin
                            state <= SHIFT;
                        end else begin
                            result_o <= alu_res;
                            zero_o   <= (alu_res == '0);
                            valid_o  <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    shreg <= shift_next;
                    cnt   <= cnt - 1'b1;
                    if (cnt == 1) begin
                        result_o <= shift_next;
                        zero_o   <= (shift_next == '0);
                        valid_o  <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        valid_o <= 1'b0;
                        ready_o <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Execute-stage ALU that consumes the 4-bit ALU_OP code produced by the ALU control decoder and computes the result with a valid/ready handshake on both sides.
- Logic, arithmetic and compare ops complete in one cycle.
- Shifts run on an iterative one-bit-per-cycle shifter to save area; latency depends on the shift amount.
- Sits between the decode/control stage (upstream) and the writeback/branch logic (downstream).

Parameters:
- WIDTH, 32, datapath width in bits. Must be a power of 2 and at least 8.
- SHAMT_W is a localparam equal to log2(WIDTH). It is not overridable.

Ports:
- clk_i  in  1  clock; all logic is rising-edge.
- rst_i  in  1  synchronous active-high reset.
- valid_i  in  1  upstream operation valid.
- ready_o  out  1  block can accept an operation.
- ALU_OP_i  in  4  operation code.
- SRC_A_i  in  WIDTH  operand A.
- SRC_B_i  in  WIDTH  operand B; the shift amount is SRC_B_i[SHAMT_W-1:0].
- valid_o  out  1  result valid.
- ready_i  in  1  downstream accepts the result.
- result_o  out  WIDTH  result.
- zero_o  out  1  high when result_o equals 0; used for branch decisions.

Behaviour:
- Reset: reset is synchronous; rst_i is sampled on the rising edge of clk_i.
  - State goes to IDLE.
  - ready_o=1, valid_o=0, result_o=0, zero_o=1.
  - rst_i has priority over every other event, including mid-shift and a result pending in DONE. An in-flight op is discarded without producing valid_o.
- State machine (IDLE, SHIFT, DONE):
  - IDLE: ready_o=1, valid_o=0. An op is accepted when valid_i and ready_o are both high. Operands and the op code are captured into internal registers.
    - Non-shift op: the result is computed from the inputs and registered; go to DONE.
    - Shift op (0100, 0101, 0111) with shamt=0: result=A; go to DONE.
    - Shift op with shamt>0: load A into the shift register and shamt into a down-counter; go to SHIFT.
  - SHIFT: ready_o=0, valid_o=0.
    - Each cycle, shift the register by one bit and decrement the counter.
    - When the counter reaches 1 on the current cycle, the final shift is performed and the state goes to DONE.
    - valid_i is ignored in this state.
  - DONE: valid_o=1, ready_o=0. result_o and zero_o hold stable until valid_o and ready_i are both high; then go to IDLE.
    - No new op is accepted in the same cycle. The minimum issue interval is 2 cycles.
- Latency from the acceptance edge to valid_o:
  - Non-shift ops, and shifts with shamt=0: 1 cycle.
  - Shifts with shamt>0: shamt+1 cycles.
- Operations; A and B are the captured operands:
  - 0000 AND: A&B.
  - 0001 OR: A|B.
  - 0010 ADD: A+B, modulo 2^WIDTH; the carry is discarded.
  - 1010 SUB: A-B, modulo 2^WIDTH.
  - 1000 XOR: A^B.
  - 0011 EQ: 1 if A==B, else 0.
  - 1100 GE: 1 if A>=B signed.
  - 1101 GEU: 1 if A>=B unsigned.
  - 1110 SLT: 1 if A<B signed.
  - 1111 SLTU: 1 if A<B unsigned.
  - 0100 SLL: shift left, zero fill.
  - 0101 SRL: shift right, zero fill.
  - 0111 SRA: shift right, filling with the sign bit of A. The sign bit is captured at acceptance.
  - All other codes (0110, 1001, 1011): result 0.
  - Compare results are zero-extended to WIDTH.
- zero_o is registered together with result_o and always equals (result_o==0).
- Inputs may change freely after acceptance; only the captured values are used.
- valid_o is never asserted in the cycle an op is accepted.

Test Plan:
- Reset, then ADD A=0x7FFFFFFF, B=1, ready_i=1 -> valid_o one cycle after accept; result_o=0x80000000; zero_o=0; ready_o back to 1 the following cycle.
- SUB A=5, B=5 -> result_o=0, zero_o=1. Then SLT A=0xFFFFFFFF, B=1 -> 1. Then SLTU with the same operands -> 0. Then GEU A=3, B=3 -> 1.
- SRA A=0x80000000, B=31 -> valid_o exactly 32 cycles after accept; result_o=0xFFFFFFFF; ready_o low throughout. SRL with the same operands -> 0x00000001.
- SLL A=0x1, B=0x20 (shamt=0) -> 1-cycle latency, result_o=0x1. Toggle valid_i during a 10-cycle shift -> no second op is accepted.
- Backpressure: XOR A=0xF0F0, B=0x0FF0 with ready_i held low for 5 cycles -> result_o=0xFF00 and valid_o stay stable throughout; on ready_i=1 -> IDLE; ready_o=1 the next cycle.
- Assert rst_i in the 4th cycle of a SLL with shamt=20 -> next cycle valid_o=0, ready_o=1, result_o=0, zero_o=1. Then an unknown op 1011 -> result_o=0, zero_o=1.
